tlb_test_seq: RTL

- Parametrised, synthesizable self-test sequencer for a MIPS-style TLB with one write port, one read port and NUM_SEARCH search ports.
- Writes a deterministic pattern into every entry, reads it back, then runs hit, global-bit and miss searches on all search ports.
- Reports w_ok/r_ok/s_ok pass flags, progress counters and a sticky test_error.
- Sits beside the TLB under test in the TLB test top; the simulation testbench and board LEDs observe its flags.

---
 rtl/tlb_test_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/tlb_test_seq.sv
// tlb_test_seq: self-test sequencer for a MIPS-style TLB (write, read-back, hit/global/miss searches).
// Define TLB_TEST_ERRCNT_EN to run every phase to completion and count mismatches on err_cnt.
module tlb_test_seq #(
    parameter int TLBNUM = 16,
    parameter int NUM_SEARCH = 2,
    parameter int VPN2_W = 19,
    parameter int ASID_W = 8,
    parameter int PFN_W = 20,
    parameter int LAT = 0,
    parameter logic [VPN2_W-1:0] VPN_BASE = 19'h00100,
    parameter logic [PFN_W-1:0] PFN_BASE = 20'h08000,
    parameter logic [ASID_W-1:0] ASID_XOR = 8'h5A,
    localparam int IDX_W = $clog2(TLBNUM),
    localparam int E_W = VPN2_W + ASID_W + 1 + 2 * PFN_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic                           w_en,
    output logic [IDX_W-1:0]               w_index,
    output logic [E_W-1:0]                 w_entry,
    output logic [IDX_W-1:0]               r_index,
    input  logic [E_W-1:0]                 r_entry,
    output logic [NUM_SEARCH*VPN2_W-1:0]   s_vpn2,
    output logic [NUM_SEARCH-1:0]          s_odd,
    output logic [NUM_SEARCH*ASID_W-1:0]   s_asid,
    input  logic [NUM_SEARCH-1:0]          s_found,
    input  logic [NUM_SEARCH*IDX_W-1:0]    s_index,
    input  logic [NUM_SEARCH*PFN_W-1:0]    s_pfn,
    output logic                           w_ok,
    output logic                           r_ok,
    output logic                           s_ok,
    output logic                           test_error,
    output logic [IDX_W:0]                 r_cnt,
    output logic [IDX_W+1:0]               s_test_id,
    output logic [1:0]                     err_port
`ifdef TLB_TEST_ERRCNT_EN
    ,
    output logic [7:0]                     err_cnt
`endif
);

    localparam int CW = IDX_W + 2;
    localparam logic [CW-1:0] LAST_R = CW'(TLBNUM - 1);
    localparam logic [CW-1:0] LAST_S = CW'(2 * TLBNUM - 1);
    localparam logic [IDX_W:0] MISS_I = (IDX_W + 1)'(TLBNUM);
`ifdef TLB_TEST_ERRCNT_EN
    localparam bit STOP = 1'b0;
`else
    localparam bit STOP = 1'b1;
`endif

    typedef enum logic [2:0] {IDLE, WRITE, READ, SEARCH, MISS, DONE, ERROR} state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic ph, ph_n, cmp, rf, fail, rs, srch, miss, s_bad;
    logic [NUM_SEARCH-1:0] pf, xf;
    logic [1:0] fp;
    logic [IDX_W-1:0] e [NUM_SEARCH];

    function automatic logic [VPN2_W-1:0] pvpn(input logic [IDX_W:0] i);
        return VPN_BASE + VPN2_W'(i);
    endfunction

    function automatic logic [ASID_W-1:0] pasid(input logic [IDX_W-1:0] i);
        return ASID_W'(i) ^ ASID_XOR;
    endfunction

    function automatic logic [PFN_W-1:0] ppfn(input logic [IDX_W-1:0] i, input logic odd);
        return PFN_BASE + (PFN_W'(i) << 1) + PFN_W'(odd);
    endfunction

    function automatic logic [E_W-1:0] pat(input logic [IDX_W-1:0] i);
        return {pvpn({1'b0, i}), pasid(i), i[0], ppfn(i, 1'b0), ppfn(i, 1'b1)};
    endfunction

    // Port p looks at entry (k>>1)+p so every port sweeps all entries in a different order
    for (genvar i = 0; i < NUM_SEARCH; i++) begin : g_e
        assign e[i] = cnt[IDX_W:1] + IDX_W'(i);
    end

    assign srch = state == SEARCH;
    assign miss = state == MISS;
    assign cmp = (LAT == 0) | ph;
    assign r_index = state == READ ? cnt[IDX_W-1:0] : '0;
    assign rf = state == READ && r_entry != pat(cnt[IDX_W-1:0]);
    assign fail = cmp && (rf || |pf);
    assign rs = start && (state == IDLE || state == DONE);

    always_comb begin
        s_vpn2 = '0;
        s_odd = '0;
        s_asid = '0;
        pf = '0;
        xf = '0;
        fp = '0;
        for (int p = 0; p < NUM_SEARCH; p++) begin
            xf[p] = cnt[1] | e[p][0];
            s_vpn2[p*VPN2_W +: VPN2_W] = srch ? pvpn({1'b0, e[p]}) : miss ? pvpn(MISS_I) : '0;
            s_odd[p] = srch & cnt[0];
            s_asid[p*ASID_W +: ASID_W] = srch ? (cnt[1] ? pasid(e[p]) : ~pasid(e[p])) :
                                         miss ? ASID_XOR : '0;
            pf[p] = srch ? (s_found[p] != xf[p] ||
                            (xf[p] && (s_index[p*IDX_W +: IDX_W] != e[p] ||
                                       s_pfn[p*PFN_W +: PFN_W] != ppfn(e[p], cnt[0])))) :
                           miss & s_found[p];
        end
        for (int p = NUM_SEARCH - 1; p >= 0; p--)
            if (pf[p]) fp = 2'(p);
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        ph_n = 1'b0;
        case (state)
            IDLE, DONE: if (start) begin
                state_n = WRITE;
                cnt_n = '0;
            end
            WRITE: begin
                state_n = cnt == LAST_R ? READ : WRITE;
                cnt_n = cnt == LAST_R ? '0 : cnt + 1'b1;
            end
            READ, SEARCH, MISS: begin
                ph_n = ~cmp;
                if (cmp) begin
                    if (fail && STOP)
                        state_n = ERROR;
                    else if (state == READ && cnt == LAST_R) begin
                        state_n = SEARCH;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                        if (state == MISS)
                            state_n = DONE;
                        else if (state == SEARCH && cnt == LAST_S)
                            state_n = MISS;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            ph <= 1'b0;
            w_en <= 1'b0;
            w_index <= '0;
            w_entry <= '0;
            w_ok <= 1'b0;
            r_ok <= 1'b0;
            s_ok <= 1'b0;
            s_bad <= 1'b0;
            test_error <= 1'b0;
            r_cnt <= '0;
            s_test_id <= '0;
            err_port <= '0;
`ifdef TLB_TEST_ERRCNT_EN
            err_cnt <= '0;
`endif
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            ph <= ph_n;
            // Write strobe and data come straight from flops so the TLB never sees decode glitches
            w_en <= state_n == WRITE;
            w_index <= state_n == WRITE ? cnt_n[IDX_W-1:0] : '0;
            w_entry <= state_n == WRITE ? pat(cnt_n[IDX_W-1:0]) : '0;
            if (rs) begin
                w_ok <= 1'b0;
                r_ok <= 1'b0;
                s_ok <= 1'b0;
                s_bad <= 1'b0;
                test_error <= 1'b0;
                r_cnt <= '0;
                s_test_id <= '0;
                err_port <= '0;
`ifdef TLB_TEST_ERRCNT_EN
                err_cnt <= '0;
`endif
            end else begin
                if (state == WRITE && cnt == LAST_R)
                    w_ok <= 1'b1;
                if (state == READ && cmp && cnt == LAST_R && !fail && !test_error)
                    r_ok <= 1'b1;
                if (miss && cmp && !fail && !s_bad)
                    s_ok <= 1'b1;
                if (fail) begin
                    test_error <= 1'b1;
                    s_bad <= s_bad | (state != READ);
                    if (!test_error)
                        err_port <= fp;
                end
                if (!test_error && !fail) begin
                    r_cnt <= state_n == READ ? {1'b0, cnt_n[IDX_W-1:0]} : r_cnt;
                    s_test_id <= (state_n == SEARCH || state_n == MISS) ? cnt_n : s_test_id;
                end
`ifdef TLB_TEST_ERRCNT_EN
                if (fail && err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 8'd1;
`endif
            end
        end
    end

endmodule
